// File: rtl/bus_arbiter.sv
// Memory bus arbiter: exec-over-fetch CPU arbitration with an optional OAM DMA engine.
// The DMA engine is built only when BUS_ARBITER_DMA_EN is defined.
module bus_arbiter #(
    parameter logic [15:0] OAM_ADDR = 16'h2004,
    parameter int unsigned DMA_LEN  = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rdy,
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    output logic        fetch_gnt,
    input  logic        exec_req,
    input  logic        exec_we,
    input  logic [15:0] exec_addr,
    input  logic [7:0]  exec_wdata,
    output logic        exec_gnt,
    input  logic        dma_start,
    input  logic [7:0]  dma_page,
    output logic        dma_busy,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_en,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  rdata,
    output logic        rvalid,
    output logic        rsrc
);

    logic        cpu_slot;
    logic        dma_rd_cyc;
    logic        dma_wr_cyc;
    logic [15:0] dma_src_addr;
    logic        exec_win;
    logic        fetch_win;

`ifdef BUS_ARBITER_DMA_EN
    typedef enum logic [1:0] {
        IDLE,
        DMA_ALIGN,
        DMA_RD,
        DMA_WR
    } state_t;

    localparam logic [7:0] LAST_BYTE = 8'(DMA_LEN - 1);

    state_t     state;
    logic [7:0] count;
    logic [7:0] page;

    // rdy low freezes the whole engine, including acceptance of dma_start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            page     <= '0;
            dma_busy <= 1'b0;
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    if (dma_start) begin
                        page     <= dma_page;
                        count    <= '0;
                        state    <= DMA_ALIGN;
                        dma_busy <= 1'b1;
                    end
                end
                DMA_ALIGN: state <= DMA_RD;
                DMA_RD:    state <= DMA_WR;
                DMA_WR: begin
                    if (count == LAST_BYTE) begin
                        state    <= IDLE;
                        dma_busy <= 1'b0;
                    end else begin
                        count <= count + 8'd1;
                        state <= DMA_RD;
                    end
                end
                default: begin
                    state    <= IDLE;
                    dma_busy <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_slot     = (state == IDLE);
    assign dma_rd_cyc   = !reset && rdy && (state == DMA_RD);
    assign dma_wr_cyc   = !reset && rdy && (state == DMA_WR);
    assign dma_src_addr = {page, count};
`else
    logic unused_dma_inputs;

    assign unused_dma_inputs = ^{dma_start, dma_page, 8'(DMA_LEN)};
    assign dma_busy          = 1'b0;
    assign cpu_slot          = 1'b1;
    assign dma_rd_cyc        = 1'b0;
    assign dma_wr_cyc        = 1'b0;
    assign dma_src_addr      = '0;
`endif

    assign exec_win  = !reset && rdy && cpu_slot && exec_req;
    assign fetch_win = !reset && rdy && cpu_slot && fetch_req && !exec_req;
    assign exec_gnt  = exec_win;
    assign fetch_gnt = fetch_win;
    assign rdata     = reset ? '0 : mem_rdata;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dma_rd_cyc) begin
            mem_en   = 1'b1;
            mem_addr = dma_src_addr;
        end else if (dma_wr_cyc) begin
            // Byte read in the previous DMA_RD cycle is forwarded straight to OAM.
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = OAM_ADDR;
            mem_wdata = mem_rdata;
        end else if (exec_win) begin
            mem_en    = 1'b1;
            mem_we    = exec_we;
            mem_addr  = exec_addr;
            mem_wdata = exec_wdata;
        end else if (fetch_win) begin
            mem_en   = 1'b1;
            mem_addr = fetch_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid <= 1'b0;
            rsrc   <= 1'b0;
        end else begin
            rvalid <= fetch_win || (exec_win && !exec_we);
            rsrc   <= exec_win && !exec_we;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: randomized CPU traffic plus DMA scenarios
// against a progress-counter reference model (DMA scenarios need BUS_ARBITER_DMA_EN).
module tb_bus_arbiter;

    localparam logic [15:0] OAM = 16'h2004;
    localparam int unsigned LEN = 256;
`ifdef BUS_ARBITER_DMA_EN
    localparam bit DMA_ON = 1'b1;
`else
    localparam bit DMA_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, rdy;
    logic        fetch_req, exec_req, exec_we, dma_start;
    logic [15:0] fetch_addr, exec_addr;
    logic [7:0]  exec_wdata, dma_page;
    logic        fetch_gnt, exec_gnt, dma_busy, mem_we, mem_en, rvalid, rsrc;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, rdata;
    logic [7:0]  mem_rdata = '0;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    bit          m_busy = 1'b0;
    int unsigned m_prog = 0;
    logic [7:0]  m_page = '0;
    bit          m_rvalid = 1'b0;
    bit          m_rsrc = 1'b0;

    int unsigned busy_cnt;
    logic [7:0]  oam_log[$];
    logic [15:0] rd_log[$];

    always #5 clk = ~clk;

    bus_arbiter #(.OAM_ADDR(OAM), .DMA_LEN(LEN)) dut (
        .clk(clk), .reset(reset), .rdy(rdy),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .exec_req(exec_req), .exec_we(exec_we), .exec_addr(exec_addr),
        .exec_wdata(exec_wdata), .exec_gnt(exec_gnt),
        .dma_start(dma_start), .dma_page(dma_page), .dma_busy(dma_busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_en(mem_en),
        .mem_rdata(mem_rdata), .rdata(rdata), .rvalid(rvalid), .rsrc(rsrc)
    );

    // Read-only memory whose contents are a fixed function of the address; page 02 holds 0..255.
    function automatic logic [7:0] rom(input logic [15:0] a);
        return a[7:0] ^ (a[15:8] - 8'd2);
    endfunction

    always @(posedge clk) if (mem_en && !mem_we) mem_rdata <= rom(mem_addr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic void model_reset();
        m_busy = 1'b0; m_prog = 0; m_page = '0; m_rvalid = 1'b0; m_rsrc = 1'b0;
    endfunction

    // DMA progress p: 0 = align, odd = read of byte (p-1)/2, even = write of that byte.
    function automatic void predict(output logic [38:0] e, output bit rd_gnt, output bit ex_gnt);
        logic fg, eg, en, we;
        logic [15:0] a;
        logic [7:0] wd, b;
        int unsigned bi;
        fg = 0; eg = 0; en = 0; we = 0; a = '0; wd = '0; rd_gnt = 0;
        if (!reset && rdy) begin
            if (m_busy) begin
                if (m_prog != 0) begin
                    bi = (m_prog - 1) / 2;
                    b  = bi[7:0];
                    en = 1;
                    if (m_prog % 2 == 1) a = {m_page, b};
                    else begin we = 1; a = OAM; wd = rom({m_page, b}); end
                end
            end else if (exec_req) begin
                eg = 1; en = 1; a = exec_addr; we = exec_we; wd = exec_wdata; rd_gnt = !exec_we;
            end else if (fetch_req) begin
                fg = 1; en = 1; a = fetch_addr; rd_gnt = 1;
            end
        end
        ex_gnt = eg;
        e = {fg, eg, m_busy && !reset, a, wd, we, en, reset ? 8'h00 : mem_rdata,
             m_rvalid && !reset, m_rsrc && !reset};
    endfunction

    task automatic settle();
        logic [38:0] e;
        bit r, g;
        @(negedge clk);
        if (reset) model_reset();
        predict(e, r, g);
        check("outs", {fetch_gnt, exec_gnt, dma_busy, mem_addr, mem_wdata, mem_we, mem_en,
                       rdata, rvalid, rsrc}, e);
        if (dma_busy) busy_cnt++;
        if (mem_en && mem_we && mem_addr == OAM) oam_log.push_back(mem_wdata);
        if (dma_busy && mem_en && !mem_we) rd_log.push_back(mem_addr);
    endtask

    task automatic advance();
        logic [38:0] e;
        bit r, g;
        predict(e, r, g);
        @(posedge clk);
        if (reset) model_reset();
        else begin
            m_rvalid = r;
            m_rsrc   = r && g;
            if (rdy) begin
                if (m_busy) begin
                    m_prog++;
                    if (m_prog == 2 * LEN + 1) m_busy = 0;
                end else if (DMA_ON && dma_start) begin
                    m_busy = 1; m_prog = 0; m_page = dma_page;
                end
            end
        end
        #1;
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic clear_logs();
        busy_cnt = 0;
        oam_log.delete();
        rd_log.delete();
    endtask

    // Requesters hold req/addr/data until they see their grant.
    task automatic cpu_random(input int unsigned cycles, input bit rand_rdy);
        bit f_pend = 0, e_pend = 0;
        for (int unsigned i = 0; i < cycles; i++) begin
            if (!f_pend && $urandom_range(0, 2) != 0) begin
                f_pend = 1; fetch_addr = 16'($urandom);
            end
            if (!e_pend && $urandom_range(0, 1) == 1) begin
                e_pend = 1; exec_addr = 16'($urandom); exec_we = 1'($urandom); exec_wdata = 8'($urandom);
            end
            fetch_req = f_pend;
            exec_req  = e_pend;
            rdy       = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            dma_start = ($urandom_range(0, 63) == 0);
            dma_page  = 8'($urandom);
            settle();
            if (fetch_gnt) f_pend = 0;
            if (exec_gnt) e_pend = 0;
            advance();
        end
        fetch_req = 0; exec_req = 0; dma_start = 0; rdy = 1;
    endtask

    task automatic drain();
        for (int unsigned i = 0; i < 1200 && m_busy; i++) cycle();
        check("drain_idle", {63'd0, dma_busy}, 64'd0);
    endtask

    task automatic start_dma(input logic [7:0] pg);
        dma_start = 1; dma_page = pg;
        cycle();
        dma_start = 0;
    endtask

    initial begin
        reset = 1; rdy = 1; fetch_req = 1; fetch_addr = 16'h1234; exec_req = 1; exec_we = 1;
        exec_addr = 16'h5678; exec_wdata = 8'hFF; dma_start = 1; dma_page = 8'h09;
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            settle();
            check("reset_outs", {fetch_gnt, exec_gnt, dma_busy, mem_addr, mem_wdata, mem_we,
                                 mem_en, rdata, rvalid, rsrc}, 64'd0);
            advance();
        end
        reset = 0; fetch_req = 0; exec_req = 0; dma_start = 0;
        cycle();

        // exec over fetch, then fetch; rvalid/rsrc follow one cycle later
        fetch_req = 1; fetch_addr = 16'h8000; exec_req = 1; exec_we = 0; exec_addr = 16'h0010;
        settle();
        check("prio_c1_exec_gnt", {63'd0, exec_gnt}, 64'd1);
        check("prio_c1_addr", {48'd0, mem_addr}, 64'h0010);
        advance();
        exec_req = 0;
        settle();
        check("prio_c2_fetch_gnt", {63'd0, fetch_gnt}, 64'd1);
        check("prio_c2_addr", {48'd0, mem_addr}, 64'h8000);
        check("prio_c2_rvalid_rsrc", {62'd0, rvalid, rsrc}, 64'd3);
        advance();
        fetch_req = 0; rdy = 0;
        settle();
        check("stall_rvalid_rsrc", {62'd0, rvalid, rsrc}, 64'd2);
        check("stall_mem_en", {63'd0, mem_en}, 64'd0);
        advance();
        rdy = 1;

        exec_req = 1; exec_we = 1; exec_addr = 16'h0200; exec_wdata = 8'hA5;
        settle();
        check("wr_we_data", {55'd0, mem_we, mem_wdata}, {55'd0, 1'b1, 8'hA5});
        advance();
        exec_req = 0;
        settle();
        check("wr_no_rvalid", {63'd0, rvalid}, 64'd0);
        advance();

        cpu_random(400, 1'b1);
        drain();

`ifdef BUS_ARBITER_DMA_EN
        // full DMA of page 02 with a fetch held throughout
        clear_logs();
        fetch_req = 1; fetch_addr = 16'hC000;
        dma_start = 1; dma_page = 8'h02;
        settle();
        check("start_cycle_fetch_gnt", {63'd0, fetch_gnt}, 64'd1);
        advance();
        dma_start = 0;
        for (int i = 0; i < 520; i++) cycle();
        fetch_req = 0;
        check("full_busy_cycles", 64'(busy_cnt), 64'd513);
        check("full_oam_writes", 64'(oam_log.size()), 64'd256);
        begin
            int unsigned bad = 0;
            foreach (oam_log[i]) if (oam_log[i] != 8'(i)) bad++;
            check("full_data_order", 64'(bad), 64'd0);
        end

        // rdy stall of 5 cycles just before the read of byte 0x10
        clear_logs();
        start_dma(8'h03);
        for (int k = 0; k < 530; k++) begin
            rdy = !(k >= 33 && k < 38);
            cycle();
        end
        rdy = 1;
        check("stall_busy_cycles", 64'(busy_cnt), 64'd518);
        check("stall_reads", 64'(rd_log.size()), 64'd256);
        check("stall_resume_addr", {48'd0, rd_log[16]}, 64'h0310);
        check("stall_resume_data", {56'd0, oam_log[16]}, 64'h11);

        // reset just as byte 0x40 would be read, then a fresh restart
        clear_logs();
        start_dma(8'h04);
        for (int k = 0; k < 129; k++) cycle();
        reset = 1;
        settle();
        check("abort_busy_en", {62'd0, dma_busy, mem_en}, 64'd0);
        advance();
        reset = 0;
        start_dma(8'h04);
        cycle();
        settle();
        check("restart_addr", {48'd0, mem_addr}, 64'h0400);
        advance();
        drain();

        // second start while busy must not change the page
        clear_logs();
        start_dma(8'h05);
        for (int k = 0; k < 520; k++) begin
            dma_start = (k == 50);
            dma_page  = (k == 50) ? 8'h07 : 8'h00;
            cycle();
        end
        dma_start = 0;
        begin
            int unsigned off = 0;
            foreach (rd_log[i]) if (rd_log[i][15:8] != 8'h05) off++;
            check("ignore_reads_in_page", 64'(off), 64'd0);
        end
        check("ignore_reads_count", 64'(rd_log.size()), 64'd256);
        check("ignore_busy_cycles", 64'(busy_cnt), 64'd513);
`else
        // no DMA engine: start pulses have no effect
        clear_logs();
        dma_start = 1; dma_page = 8'h02; exec_req = 1; exec_we = 0; exec_addr = 16'h0300;
        settle();
        check("nodma_exec_gnt", {63'd0, exec_gnt}, 64'd1);
        advance();
        dma_start = 0; exec_req = 0;
        for (int i = 0; i < 10; i++) cycle();
        check("nodma_busy_cycles", 64'(busy_cnt), 64'd0);
`endif

        cpu_random(200, 1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter OAM_ADDR, default 16'h2004, which is the fixed DMA write target address.
REQ-002 The block SHALL have parameter DMA_LEN, default 256, which is the number of bytes per DMA; legal range is 1..256.
REQ-003 The block SHALL have one clock, and its reset SHALL be asynchronous and active-high, with ports as follows:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous reset, active-high.
- rdy  in  1  bus-ready; low stalls all new bus cycles.
- fetch_req  in  1  instruction fetch read request.
- fetch_addr  in  16  fetch address.
- fetch_gnt  out  1  fetch granted this cycle.
- exec_req  in  1  execute-stage memory request.
- exec_we  in  1  1 = write, 0 = read.
- exec_addr  in  16  execute address.
- exec_wdata  in  8  execute write data.
- exec_gnt  out  1  execute granted this cycle.
- dma_start  in  1  one-cycle DMA trigger pulse.
- dma_page  in  8  DMA source page (high address byte).
- dma_busy  out  1  DMA in progress; CPU requesters locked out.
- mem_addr  out  16  memory address.
- mem_wdata  out  8  memory write data.
- mem_we  out  1  memory write enable.
- mem_en  out  1  memory cycle valid.
- mem_rdata  in  8  synchronous read data, valid in the cycle after a read mem_en.
- rdata  out  8  read data returned to the CPU (equals mem_rdata).
- rvalid  out  1  rdata valid for the previous cycle's CPU read.
- rsrc  out  1  owner of rvalid: 0 = fetch, 1 = exec.

Function
REQ-004 The block SHALL implement a state machine with states IDLE, DMA_ALIGN, DMA_RD and DMA_WR; CPU arbitration SHALL occur only in IDLE.
REQ-005 In IDLE with rdy=1, the block SHALL grant exactly one requester per cycle; exec SHALL take priority over fetch.
REQ-006 A grant SHALL be combinational: gnt, mem_en, mem_addr, mem_we and mem_wdata SHALL be driven from the winner's inputs in the same cycle.
REQ-007 mem_we SHALL equal exec_we for an exec grant and SHALL be 0 for a fetch grant.
REQ-008 A requester SHALL hold its req, addr and data stable until it samples its gnt high; the arbiter SHALL NOT queue requests.
REQ-009 rvalid SHALL be a register set on the edge ending a granted CPU read, so that it is high for exactly one cycle; rsrc SHALL be registered alongside it.
REQ-010 A CPU write SHALL NOT produce rvalid.
REQ-011 When rdy=0, the block SHALL drive mem_en=0, fetch_gnt=0 and exec_gnt=0, and DMA state and counter SHALL hold.
REQ-012 When rdy=0, a pending rvalid SHALL still be delivered.
REQ-013 When dma_start=1 in IDLE, the block SHALL latch dma_page, clear the byte counter, and enter DMA_ALIGN at the next edge.
REQ-014 CPU grants in the dma_start cycle SHALL proceed normally.
REQ-015 dma_busy SHALL be 1 in DMA_ALIGN, DMA_RD and DMA_WR; fetch_gnt and exec_gnt SHALL be 0 while dma_busy=1.
REQ-016 DMA_ALIGN SHALL last one cycle with mem_en=0, then transition to DMA_RD.
REQ-017 In DMA_RD, the block SHALL drive mem_en=1, mem_we=0 and mem_addr={page, count}, then transition to DMA_WR.
REQ-018 In DMA_WR, the block SHALL drive mem_en=1, mem_we=1, mem_addr=OAM_ADDR and mem_wdata=mem_rdata, then increment count.
REQ-019 After the DMA_WR cycle for count = DMA_LEN-1, the block SHALL go to IDLE; otherwise it SHALL go to DMA_RD.
REQ-020 The 8-bit counter SHALL terminate on reaching DMA_LEN-1 and SHALL NOT wrap into a second pass; a DMA SHALL take exactly 1 + 2*DMA_LEN active cycles.
REQ-021 DMA reads SHALL NOT assert rvalid.
REQ-022 dma_start while dma_busy=1 SHALL be ignored, and the latched page SHALL NOT change.
REQ-023 When not granting, the block SHALL drive mem_addr, mem_wdata and mem_we to 0.

Reset
REQ-024 While reset=1, all outputs SHALL be 0, state SHALL be IDLE, and the counter and latched page SHALL be 0.
REQ-025 Reset during a DMA SHALL abort it immediately with no further memory cycles.
REQ-026 After reset deasserts, the block SHALL arbitrate from the next rising edge.

Configuration
REQ-027 With macro BUS_ARBITER_DMA_EN defined, the DMA engine SHALL be present as specified above.
REQ-028 Without BUS_ARBITER_DMA_EN: dma_start and dma_page SHALL be ignored, dma_busy SHALL be tied 0, only IDLE SHALL exist, and CPU arbitration SHALL be unchanged.

Verification
REQ-029 Scenario (priority): fetch_req=1 @16'h8000 and exec_req=1 read @16'h0010, both held -> cycle 1 exec_gnt=1, mem_addr=16'h0010; cycle 2 fetch_gnt=1, mem_addr=16'h8000, rvalid=1, rsrc=1.
REQ-030 Scenario (exec write): exec write 8'hA5 @16'h0200 -> mem_we=1, mem_wdata=8'hA5 in the grant cycle; rvalid stays 0.
REQ-031 Scenario (full DMA): dma_page=8'h02, memory preloaded with bytes i = 0..255 -> exactly 513 busy cycles; 256 writes to 16'h2004 with data 0..255 in order; fetch_req held throughout gets no grant until busy falls.
REQ-032 Scenario (rdy stall): rdy=0 for 5 cycles mid-DMA at count=8'h10 -> mem_en=0 during the stall; the DMA resumes at count 8'h10; total busy = 518 cycles.
REQ-033 Scenario (reset abort): reset pulse during DMA at count=8'h40 -> all outputs 0 next cycle, dma_busy=0; a fresh dma_start restarts at address {page, 8'h00}.
REQ-034 Scenario (start ignored): second dma_start with page 8'h07 while busy -> ignored; all reads stay in the original page.
